// File: rtl/auth_blk_gen.sv
// Rider authorization FSM: turns BLE command bytes into pwr_up, with an optional access key,
// a wrong-key lockout and a link-loss heartbeat timeout that performs a safe stop.
module auth_blk_gen #(
  parameter logic [7:0]  GO_CMD    = 8'h47,
  parameter logic [7:0]  STOP_CMD  = 8'h53,
  parameter int unsigned KEY_LEN   = 0,
  parameter logic [31:0] KEY       = 32'h0000_0000,
  parameter int unsigned TIMEOUT   = 0,
  parameter int unsigned MAX_FAIL  = 3,
  parameter int unsigned LOCK_CLKS = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_rdy,
  output logic       clr_rx_rdy,
  input  logic       rider_off,
  output logic       pwr_up,
  output logic [2:0] auth_state,
  output logic       link_lost,
  output logic       locked
);

  localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned LW = (LOCK_CLKS > 0) ? $clog2(LOCK_CLKS + 1) : 1;
  localparam logic [TW-1:0] TMAX     = TW'(TIMEOUT);
  localparam logic [3:0]    FAIL_LIM = 4'(MAX_FAIL);
  localparam logic [1:0]    KEY_LAST = 2'((KEY_LEN > 0) ? KEY_LEN - 1 : 0);

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StKey  = 3'd1,
    StPwr1 = 3'd2,
    StPwr2 = 3'd3,
    StLock = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    key_idx_q, key_idx_d;
  logic [3:0]    fail_q, fail_d;
  logic [TW-1:0] timer_q, timer_d, timer_inc;
  logic [LW-1:0] lock_cnt_q, lock_cnt_d;
  logic          link_lost_q, link_lost_d;
  logic          pwr_up_q, locked_q;
  logic          rx_go, rx_stop, expired, lock_done;
  logic [3:0]    fail_next;

  // Key bytes are consumed MSB-first from the low KEY_LEN bytes of KEY.
  function automatic logic [7:0] key_byte(input logic [1:0] idx);
    logic [31:0] sh;
    sh = '0;
    if (32'(idx) < KEY_LEN) sh = KEY >> (8 * (KEY_LEN - 1 - 32'(idx)));
    return sh[7:0];
  endfunction

  assign clr_rx_rdy = rx_rdy;
  assign rx_go      = rx_rdy && (rx_data == GO_CMD);
  assign rx_stop    = rx_rdy && (rx_data == STOP_CMD);
  assign timer_inc  = (timer_q < TMAX) ? timer_q + TW'(1) : timer_q;
  // A byte arriving in the expiry cycle proves the link is alive, so it wins.
  assign expired    = (TIMEOUT != 0) && !rx_rdy && (timer_q >= TMAX);
  assign lock_done  = (32'(lock_cnt_q) + 32'd1) >= LOCK_CLKS;
  assign fail_next  = fail_q + 4'd1;

  always_comb begin
    state_d     = state_q;
    key_idx_d   = key_idx_q;
    fail_d      = fail_q;
    timer_d     = timer_q;
    lock_cnt_d  = '0;
    link_lost_d = link_lost_q;
    unique case (state_q)
      StIdle: begin
        if (rx_go) begin
          link_lost_d = 1'b0;
          timer_d     = '0;
          key_idx_d   = '0;
          if (KEY_LEN == 0) state_d = StPwr1;
          else              state_d = StKey;
        end
      end
      StKey: begin
        if (rx_rdy) begin
          timer_d = '0;
          if (rx_data == key_byte(key_idx_q)) begin
            if (key_idx_q == KEY_LAST) begin
              state_d   = StPwr1;
              fail_d    = '0;
              key_idx_d = '0;
            end else begin
              key_idx_d = key_idx_q + 2'd1;
            end
          end else begin
            fail_d    = fail_next;
            key_idx_d = '0;
            if (fail_next == FAIL_LIM) state_d = StLock;
            else                       state_d = StIdle;
          end
        end else if (expired) begin
          state_d   = StIdle;
          key_idx_d = '0;
        end else begin
          timer_d = timer_inc;
        end
      end
      StPwr1: begin
        if (rx_rdy) timer_d = '0;
        else        timer_d = timer_inc;
        if (expired) link_lost_d = 1'b1;
        // Link loss is treated exactly like a STOP command.
        if (expired || rx_stop) begin
          if (rider_off) state_d = StIdle;
          else           state_d = StPwr2;
        end
      end
      StPwr2: begin
        if (rider_off) begin
          state_d = StIdle;
        end else if (rx_go) begin
          state_d     = StPwr1;
          timer_d     = '0;
          link_lost_d = 1'b0;
        end
      end
      StLock: begin
        if (lock_done) begin
          state_d = StIdle;
          fail_d  = '0;
        end else begin
          lock_cnt_d = lock_cnt_q + LW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      key_idx_q   <= '0;
      fail_q      <= '0;
      timer_q     <= '0;
      lock_cnt_q  <= '0;
      link_lost_q <= 1'b0;
      pwr_up_q    <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_idx_q   <= key_idx_d;
      fail_q      <= fail_d;
      timer_q     <= timer_d;
      lock_cnt_q  <= lock_cnt_d;
      link_lost_q <= link_lost_d;
      pwr_up_q    <= (state_d == StPwr1) || (state_d == StPwr2);
      locked_q    <= (state_d == StLock);
    end
  end

  assign pwr_up     = pwr_up_q;
  assign auth_state = state_q;
  assign link_lost  = link_lost_q;
  assign locked     = locked_q;

endmodule

// File: tb/tb_auth_blk_gen.sv
// Scoreboard bench for auth_blk_gen: one default instance (no key) and one keyed instance
// with heartbeat timeout and a short lockout.
module tb_auth_blk_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_rdy;
  logic       rider_off;

  logic       clr_a, pwr_a, ll_a, lk_a;
  logic [2:0] st_a;
  logic       clr_b, pwr_b, ll_b, lk_b;
  logic [2:0] st_b;

  logic       sel;
  logic [5:0] obs_a, obs_b, obs;

  int n_checks = 0;
  int n_errors = 0;

  logic [5:0] exp_q[$];
  string      tag_q[$];

  always #5 clk = ~clk;

  auth_blk_gen u_dut_a (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_rdy    (rx_rdy),
    .clr_rx_rdy(clr_a),
    .rider_off (rider_off),
    .pwr_up    (pwr_a),
    .auth_state(st_a),
    .link_lost (ll_a),
    .locked    (lk_a)
  );

  auth_blk_gen #(
    .KEY_LEN  (2),
    .KEY      (32'h0000_A55A),
    .TIMEOUT  (1000),
    .MAX_FAIL (3),
    .LOCK_CLKS(500)
  ) u_dut_b (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_rdy    (rx_rdy),
    .clr_rx_rdy(clr_b),
    .rider_off (rider_off),
    .pwr_up    (pwr_b),
    .auth_state(st_b),
    .link_lost (ll_b),
    .locked    (lk_b)
  );

  assign obs_a = {st_a, pwr_a, ll_a, lk_a};
  assign obs_b = {st_b, pwr_b, ll_b, lk_b};
  assign obs   = sel ? obs_b : obs_a;

  function automatic logic [5:0] ex(input logic [2:0] st, input logic p, input logic ll,
                                    input logic lk);
    return {st, p, ll, lk};
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Drive one cycle of inputs, queue the expected post-edge outputs, then pop and compare.
  task automatic step(input logic [7:0] d, input logic rdy, input logic roff, input logic [5:0] e,
                      input string tag);
    logic [5:0] want;
    string      t;
    rx_data   = d;
    rx_rdy    = rdy;
    rider_off = roff;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    #1 check_val({tag, "_clr"}, 32'(sel ? clr_b : clr_a), 32'(rdy));
    @(posedge clk);
    #1;
    want = exp_q.pop_front();
    t    = tag_q.pop_front();
    check_val(t, 32'(obs), 32'(want));
  endtask

  task automatic idle(input int n, input logic roff);
    rx_rdy    = 1'b0;
    rider_off = roff;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    rst       = 1'b1;
    rx_rdy    = 1'b0;
    rider_off = 1'b0;
    exp_q.push_back(ex(3'd0, 1'b0, 1'b0, 1'b0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_val(tag, 32'(obs), 32'(exp_q.pop_front()));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic seen;
    rst       = 1'b0;
    rx_data   = 8'h00;
    rx_rdy    = 1'b0;
    rider_off = 1'b0;
    sel       = 1'b0;
    #1;

    // Defaults, no key
    do_reset("rst_a");
    check_val("rst_b", 32'(obs_b), 32'(ex(3'd0, 1'b0, 1'b0, 1'b0)));
    step(8'h53, 1'b1, 1'b0, ex(3'd0, 1'b0, 1'b0, 1'b0), "idle_ign");
    step(8'h47, 1'b1, 1'b0, ex(3'd2, 1'b1, 1'b0, 1'b0), "go");
    step(8'h47, 1'b1, 1'b0, ex(3'd2, 1'b1, 1'b0, 1'b0), "go_ign");
    step(8'h53, 1'b1, 1'b0, ex(3'd3, 1'b1, 1'b0, 1'b0), "stop_on");
    step(8'h00, 1'b0, 1'b1, ex(3'd0, 1'b0, 1'b0, 1'b0), "roff");
    step(8'h47, 1'b1, 1'b0, ex(3'd2, 1'b1, 1'b0, 1'b0), "go2");
    step(8'h53, 1'b1, 1'b1, ex(3'd0, 1'b0, 1'b0, 1'b0), "stop_off");
    // rider_off beats GO in PWR2; GO alone resumes
    step(8'h47, 1'b1, 1'b0, ex(3'd2, 1'b1, 1'b0, 1'b0), "go3");
    step(8'h53, 1'b1, 1'b0, ex(3'd3, 1'b1, 1'b0, 1'b0), "stop3");
    step(8'h47, 1'b1, 1'b0, ex(3'd2, 1'b1, 1'b0, 1'b0), "resume");
    step(8'h53, 1'b1, 1'b0, ex(3'd3, 1'b1, 1'b0, 1'b0), "stop4");
    step(8'h47, 1'b1, 1'b1, ex(3'd0, 1'b0, 1'b0, 1'b0), "roff_prio");

    // Keyed instance: correct key, then wrong keys into lockout
    sel = 1'b1;
    do_reset("rst_b2");
    step(8'h47, 1'b1, 1'b0, ex(3'd1, 1'b0, 1'b0, 1'b0), "k_go");
    step(8'hA5, 1'b1, 1'b0, ex(3'd1, 1'b0, 1'b0, 1'b0), "k_b1");
    step(8'h5A, 1'b1, 1'b0, ex(3'd2, 1'b1, 1'b0, 1'b0), "k_b2");
    step(8'h53, 1'b1, 1'b1, ex(3'd0, 1'b0, 1'b0, 1'b0), "k_stop");
    step(8'h47, 1'b1, 1'b0, ex(3'd1, 1'b0, 1'b0, 1'b0), "w1_go");
    step(8'hA5, 1'b1, 1'b0, ex(3'd1, 1'b0, 1'b0, 1'b0), "w1_b1");
    step(8'h00, 1'b1, 1'b0, ex(3'd0, 1'b0, 1'b0, 1'b0), "bad1");
    step(8'h47, 1'b1, 1'b0, ex(3'd1, 1'b0, 1'b0, 1'b0), "w2_go");
    step(8'h00, 1'b1, 1'b0, ex(3'd0, 1'b0, 1'b0, 1'b0), "bad2");
    step(8'h47, 1'b1, 1'b0, ex(3'd1, 1'b0, 1'b0, 1'b0), "w3_go");
    step(8'hA5, 1'b1, 1'b0, ex(3'd1, 1'b0, 1'b0, 1'b0), "w3_b1");
    step(8'h11, 1'b1, 1'b0, ex(3'd4, 1'b0, 1'b0, 1'b1), "lock");
    step(8'h47, 1'b1, 1'b0, ex(3'd4, 1'b0, 1'b0, 1'b1), "lock_go");
    step(8'hA5, 1'b1, 1'b0, ex(3'd4, 1'b0, 1'b0, 1'b1), "lock_b1");
    step(8'h5A, 1'b1, 1'b0, ex(3'd4, 1'b0, 1'b0, 1'b1), "lock_b2");
    idle(495, 1'b0);
    step(8'h00, 1'b0, 1'b0, ex(3'd4, 1'b0, 1'b0, 1'b1), "lock_last");
    step(8'h00, 1'b0, 1'b0, ex(3'd0, 1'b0, 1'b0, 1'b0), "unlock");
    step(8'h47, 1'b1, 1'b0, ex(3'd1, 1'b0, 1'b0, 1'b0), "u_go");
    step(8'hA5, 1'b1, 1'b0, ex(3'd1, 1'b0, 1'b0, 1'b0), "u_b1");
    step(8'h5A, 1'b1, 1'b0, ex(3'd2, 1'b1, 1'b0, 1'b0), "u_b2");

    // Heartbeat: bytes every 900 clocks hold power, then silence trips the timeout
    for (int i = 0; i < 3; i++) begin
      idle(899, 1'b0);
      step(8'h00, 1'b1, 1'b0, ex(3'd2, 1'b1, 1'b0, 1'b0), "hb");
    end
    idle(998, 1'b0);
    step(8'h00, 1'b0, 1'b0, ex(3'd2, 1'b1, 1'b0, 1'b0), "no_early_to");
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (!seen) begin
        @(posedge clk);
        #1;
        if (ll_b) seen = 1'b1;
      end
    end
    check_val("to_seen", 32'(seen), 32'd1);
    check_val("to_state", 32'(obs_b), 32'(ex(3'd3, 1'b1, 1'b1, 1'b0)));
    idle(1200, 1'b0);
    step(8'h00, 1'b0, 1'b0, ex(3'd3, 1'b1, 1'b1, 1'b0), "pwr2_frozen");
    step(8'h00, 1'b0, 1'b1, ex(3'd0, 1'b0, 1'b1, 1'b0), "to_roff");
    step(8'h47, 1'b1, 1'b0, ex(3'd1, 1'b0, 1'b0, 1'b0), "go_clr_ll");
    step(8'hA5, 1'b1, 1'b0, ex(3'd1, 1'b0, 1'b0, 1'b0), "r_b1");
    step(8'h5A, 1'b1, 1'b0, ex(3'd2, 1'b1, 1'b0, 1'b0), "r_b2");
    idle(1005, 1'b0);
    step(8'h00, 1'b0, 1'b0, ex(3'd3, 1'b1, 1'b1, 1'b0), "to2");
    step(8'h47, 1'b1, 1'b0, ex(3'd2, 1'b1, 1'b0, 1'b0), "go_pwr2_clr");
    step(8'h53, 1'b1, 1'b1, ex(3'd0, 1'b0, 1'b0, 1'b0), "stop_off_b");
    // Abandoned key entry returns to IDLE
    step(8'h47, 1'b1, 1'b0, ex(3'd1, 1'b0, 1'b0, 1'b0), "kt_go");
    idle(1005, 1'b0);
    step(8'h00, 1'b0, 1'b0, ex(3'd0, 1'b0, 1'b0, 1'b0), "key_to");

    // Reset mid-key and while powered
    step(8'h47, 1'b1, 1'b0, ex(3'd1, 1'b0, 1'b0, 1'b0), "m_go");
    step(8'hA5, 1'b1, 1'b0, ex(3'd1, 1'b0, 1'b0, 1'b0), "m_b1");
    do_reset("rst_key");
    step(8'h5A, 1'b1, 1'b0, ex(3'd0, 1'b0, 1'b0, 1'b0), "no_resume");
    step(8'h47, 1'b1, 1'b0, ex(3'd1, 1'b0, 1'b0, 1'b0), "n_go");
    step(8'hA5, 1'b1, 1'b0, ex(3'd1, 1'b0, 1'b0, 1'b0), "n_b1");
    step(8'h5A, 1'b1, 1'b0, ex(3'd2, 1'b1, 1'b0, 1'b0), "n_b2");
    do_reset("rst_pwr");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
